bmc_sched: RTL and testbench

BMC_SCHED -- requirements
Module: bmc_sched

---
 rtl/bmc_sched.sv | 144 ++++++++++++++
 tb/tb_bmc_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmc_sched.sv
// bmc_sched -- time-shares one BMC/ACS bank across NGROUP groups per received
// symbol and paces traceback requests every TB_LEN symbols.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   rx_pair       received hard-decision symbol pair
//   rx_valid      rx_pair valid
//   rx_ready      scheduler accepts rx_pair (registered)
//   grp_pair      held symbol pair broadcast to the BMC bank
//   grp_idx       group served by the bank this cycle
//   acs_en        bank computes/writes group grp_idx this cycle
//   sym_done      one-cycle pulse on the last group of a symbol
//   sym_cnt       trellis depth count, wraps TB_LEN-1 -> 0
//   tb_req        traceback request (level), dropped once tb_ack is sampled
//   tb_ack        traceback accepted (only observed while requesting)
//   pm_ovf        ACS path-metric MSB set   (only with BMC_SCHED_NORM_EN)
//   norm_en       normalization strobe       (only with BMC_SCHED_NORM_EN)
//   fsm_state     current FSM state, for debug/checkers
//
// Handshake: a symbol transfers on a rising edge where rx_valid and rx_ready
// are both 1. The source holds rx_pair and rx_valid until that edge; rx_valid
// while rx_ready is 0 has no effect.
//
// Optional feature: define BMC_SCHED_NORM_EN to add path-metric normalization.
module bmc_sched #(
  parameter int NGROUP = 8,
  parameter int TB_LEN = 32,
  localparam int GW = $clog2(NGROUP),
  localparam int DW = $clog2(TB_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    rx_pair,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [1:0]    grp_pair,
  output logic [GW-1:0] grp_idx,
  output logic          acs_en,
  output logic          sym_done,
  output logic [DW-1:0] sym_cnt,
  output logic          tb_req,
  input  logic          tb_ack,
`ifdef BMC_SCHED_NORM_EN
  input  logic          pm_ovf,
  output logic          norm_en,
`endif
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    NORM    = 2'd2,
    TB_WAIT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          rx_ready_q;
  logic [1:0]    grp_pair_q;
  logic [GW-1:0] grp_idx_q;
  logic [DW-1:0] sym_cnt_q;
  logic          accept;
  logic          last_grp;
  logic          wrap;
  logic          ovf_pending;

  assign accept   = (state_q == IDLE) && rx_valid && rx_ready_q;
  assign last_grp = (grp_idx_q == GW'(NGROUP - 1));
  assign wrap     = (sym_cnt_q == DW'(TB_LEN - 1));

`ifdef BMC_SCHED_NORM_EN
  logic ovf_q;
  // Include this cycle's sample so an overflow on the last group still counts.
  assign ovf_pending = ovf_q || pm_ovf;
  assign norm_en     = (state_q == NORM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == NORM) begin
      ovf_q <= 1'b0;
    end else if ((state_q == RUN) && pm_ovf) begin
      ovf_q <= 1'b1;
    end
  end
`else
  assign ovf_pending = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (last_grp) begin
          if (ovf_pending)  state_d = NORM;
          else if (wrap)    state_d = TB_WAIT;
          else              state_d = IDLE;
        end
      end
      NORM: begin
        // sym_cnt already advanced; zero here means the last symbol wrapped it.
        state_d = (sym_cnt_q == '0) ? TB_WAIT : IDLE;
      end
      TB_WAIT: begin
        if (tb_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_ready_q <= 1'b0;
      grp_pair_q <= 2'b00;
      grp_idx_q  <= '0;
      sym_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      // Registered ready: high exactly while the FSM will sit in IDLE.
      rx_ready_q <= (state_d == IDLE);
      if (accept) grp_pair_q <= rx_pair;
      if ((state_q == RUN) && !last_grp) grp_idx_q <= grp_idx_q + 1'b1;
      else                               grp_idx_q <= '0;
      if ((state_q == RUN) && last_grp) begin
        sym_cnt_q <= wrap ? '0 : sym_cnt_q + 1'b1;
      end
    end
  end

  assign rx_ready  = rx_ready_q;
  assign grp_pair  = grp_pair_q;
  assign grp_idx   = grp_idx_q;
  assign acs_en    = (state_q == RUN);
  assign sym_done  = (state_q == RUN) && last_grp;
  assign sym_cnt   = sym_cnt_q;
  assign tb_req    = (state_q == TB_WAIT);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_bmc_sched.sv
// tb_bmc_sched -- directed bench for bmc_sched with a cycle model and an
// expected-pair scoreboard.
module tb_bmc_sched;
  localparam int NGROUP = 8;
  localparam int TB_LEN = 32;
  localparam int GW = $clog2(NGROUP);
  localparam int DW = $clog2(TB_LEN);
`ifdef BMC_SCHED_NORM_EN
  localparam bit NORM_BUILD = 1'b1;
`else
  localparam bit NORM_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    rx_pair = 2'b00;
  logic          rx_valid = 1'b0;
  logic          tb_ack = 1'b0;
  logic          pm_ovf = 1'b0;
  logic          rx_ready;
  logic [1:0]    grp_pair;
  logic [GW-1:0] grp_idx;
  logic          acs_en;
  logic          sym_done;
  logic [DW-1:0] sym_cnt;
  logic          tb_req;
  logic [1:0]    fsm_state;
  logic          norm_obs;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bmc_sched #(.NGROUP(NGROUP), .TB_LEN(TB_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .rx_pair(rx_pair), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .grp_pair(grp_pair), .grp_idx(grp_idx),
    .acs_en(acs_en), .sym_done(sym_done), .sym_cnt(sym_cnt),
    .tb_req(tb_req), .tb_ack(tb_ack),
`ifdef BMC_SCHED_NORM_EN
    .pm_ovf(pm_ovf), .norm_en(norm_obs),
`endif
    .fsm_state(fsm_state)
  );
`ifndef BMC_SCHED_NORM_EN
  assign norm_obs = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0] exp_q[$];
  bit m_run, m_tb, m_norm, m_rdy, m_ovf, m_pend_tb;
  int m_idx, m_cnt;
  logic [1:0] m_pair;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_tb = 0; m_norm = 0; m_rdy = 0; m_ovf = 0; m_pend_tb = 0;
      m_idx = 0; m_cnt = 0; m_pair = 2'b00;
      exp_q.delete();
    end else begin
      bit hs, wrapped;
      hs = m_rdy && rx_valid;
      if (m_run) begin
        if (pm_ovf) m_ovf = 1;
        if (m_idx == NGROUP - 1) begin
          m_run = 0; m_idx = 0;
          wrapped = (m_cnt == TB_LEN - 1);
          m_cnt = wrapped ? 0 : m_cnt + 1;
          if (NORM_BUILD && m_ovf) begin m_norm = 1; m_pend_tb = wrapped; end
          else m_tb = wrapped;
        end else begin
          m_idx++;
        end
      end else if (m_norm) begin
        m_norm = 0; m_ovf = 0; m_tb = m_pend_tb;
      end else if (m_tb) begin
        if (tb_ack) m_tb = 0;
      end else if (hs) begin
        m_run = 1; m_idx = 0; m_pair = rx_pair;
        exp_q.push_back(rx_pair);
      end
      m_rdy = !m_run && !m_tb && !m_norm;
    end
  end

  // ---------------- per-cycle monitor / scoreboard ----------------
  int norm_pulses = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      bit sd;
      sd = m_run && (m_idx == NGROUP - 1);
      chk("rx_ready", rx_ready, m_rdy);
      chk("acs_en", acs_en, m_run);
      chk("grp_idx", grp_idx, m_idx);
      chk("sym_done", sym_done, sd);
      chk("sym_cnt", sym_cnt, m_cnt);
      chk("tb_req", tb_req, m_tb);
      chk("grp_pair", grp_pair, m_pair);
      chk("norm_en", norm_obs, m_norm);
      if (norm_obs) norm_pulses++;
      if (sd) begin
        if (exp_q.size() == 0) chk("sb_empty", 1, 0);
        else chk("sb_pair", grp_pair, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one symbol; return #1 after the accepting edge. keep leaves rx_valid high.
  task automatic send_sym(input logic [1:0] p, input bit keep);
    bit done = 0;
    rx_pair = p;
    rx_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (m_rdy) done = 1;
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 0, 1);
    if (!keep) rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (m_rdy) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_grp_pair"}, grp_pair, 0);
    chk({tag, "_grp_idx"}, grp_idx, 0);
    chk({tag, "_acs_en"}, acs_en, 0);
    chk({tag, "_sym_done"}, sym_done, 0);
    chk({tag, "_sym_cnt"}, sym_cnt, 0);
    chk({tag, "_tb_req"}, tb_req, 0);
    chk({tag, "_norm_en"}, norm_obs, 0);
  endtask

  task automatic stream_to_wrap(input bit ovf_sym_last);
    int n;
    bit done = 0;
    n = TB_LEN - m_cnt;
    for (int i = 0; i < n; i++) begin
      send_sym(2'($urandom_range(0, 3)), (i != n - 1));
      if (ovf_sym_last && i == n - 1) begin
        // Raise pm_ovf for the cycle where grp_idx is 3.
        repeat (3) @(posedge clk);
        pm_ovf = 1'b1;
        @(posedge clk); #1;
        pm_ovf = 1'b0;
      end
    end
    rx_valid = 1'b1;
    for (int i = 0; i < 4 * NGROUP && !done; i++) begin
      if (m_tb) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) chk("wrap_timeout", 0, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", rx_ready, 0);
    @(posedge clk); #1;
    chk("rdy_first_edge", rx_ready, 1);

    // Single symbol latency: 2'b10 accepted, eight acs_en cycles, then ready.
    send_sym(2'b10, 0);
    for (int k = 0; k < NGROUP; k++) begin
      @(negedge clk);
      chk("lat_acs_en", acs_en, 1);
      chk("lat_grp_idx", grp_idx, k);
      chk("lat_grp_pair", grp_pair, 2'b10);
      chk("lat_sym_done", sym_done, (k == NGROUP - 1));
      chk("lat_rx_ready", rx_ready, 0);
    end
    @(negedge clk);
    chk("lat_ready_back", rx_ready, 1);
    chk("lat_acs_off", acs_en, 0);
    chk("lat_cnt", sym_cnt, 1);

    // tb_ack in IDLE and during RUN is ignored.
    tb_ack = 1'b1; @(posedge clk); #1; tb_ack = 1'b0;
    chk("ack_idle_tb_req", tb_req, 0);
    send_sym(2'b01, 0);
    repeat (2) @(posedge clk);
    #1 tb_ack = 1'b1; @(posedge clk); #1; tb_ack = 1'b0;
    chk("ack_run_acs_en", acs_en, 1);
    chk("ack_run_tb_req", tb_req, 0);
    wait_idle();

    // Random symbols with random gaps.
    for (int i = 0; i < 4; i++) begin
      send_sym(2'($urandom_range(0, 3)), 0);
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Stream until the trellis depth wraps, then delayed traceback ack.
    stream_to_wrap(0);
    @(negedge clk);
    chk("wrap_cnt", sym_cnt, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("tbw_tb_req", tb_req, 1);
      chk("tbw_rx_ready", rx_ready, 0);
    end
    #1 tb_ack = 1'b1;
    @(posedge clk); #1;
    tb_ack = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("ack_tb_req_low", tb_req, 0);
    chk("ack_rx_ready", rx_ready, 1);

`ifdef BMC_SCHED_NORM_EN
    // Overflow on the last symbol of a trellis: one NORM cycle then TB_WAIT.
    norm_pulses = 0;
    stream_to_wrap(1);
    rx_valid = 1'b0;
    chk("norm_count", norm_pulses, 1);
    #1 tb_ack = 1'b1; @(posedge clk); #1; tb_ack = 1'b0;
    norm_pulses = 0;
    send_sym(2'b11, 0);
    wait_idle();
    chk("norm_quiet", norm_pulses, 0);
`endif

    // Reset mid-RUN at grp_idx 4.
    send_sym(2'b11, 0);
    for (int i = 0; i < 20 && m_idx != 4; i++) @(negedge clk);
    chk("pre_rst_idx", grp_idx, 4);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_rst");
    @(negedge clk);
    chk("rst_no_done", sym_done, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy_low", rx_ready, 0);
    @(posedge clk); #1;
    chk("rel_rdy_high", rx_ready, 1);

    send_sym(2'b01, 0);
    wait_idle();
    @(negedge clk);
    chk("post_rst_cnt", sym_cnt, 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
